// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot frame scheduler: FSM states,
// coord_control strobe encodings and width helpers.
package mandel_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFrame,
        StSettle,
        StRow,
        StIssue,
        StDone
    } sched_state_e;

    // {next_frame, next_row} as seen by coord_control
    localparam logic [1:0] CTRL_STEP  = 2'b00;
    localparam logic [1:0] CTRL_ROW   = 2'b01;
    localparam logic [1:0] CTRL_FRAME = 2'b10;

    function automatic int unsigned idx_bits(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned x_bits(input int unsigned bits);
        return bits;
    endfunction

    function automatic int unsigned y_bits(input int unsigned bits);
        return bits - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index and wraps.
module rr_arbiter
    import mandel_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);

    localparam int unsigned LW = idx_bits(N);
    localparam int unsigned PW = idx_bits(2 * N);

    logic [LW-1:0]  r_last;
    logic [LW-1:0]  w_win;
    logic           w_hit;
    logic [2*N-1:0] w_req2;
    logic [PW-1:0]  w_pos;

    // Doubled request vector turns the wrapping search into a linear scan.
    always_comb begin
        w_req2 = {req, req};
        w_hit  = 1'b0;
        w_win  = r_last;
        w_pos  = '0;
        for (int o = 1; o <= int'(N); o++) begin
            w_pos = PW'(r_last) + PW'(o);
            if (!w_hit && w_req2[w_pos]) begin
                w_hit = 1'b1;
                w_win = (w_pos >= PW'(N)) ? LW'(w_pos - PW'(N)) : LW'(w_pos);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (en && w_hit) begin
            grant[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= LW'(N - 1);
        end else if (en && w_hit) begin
            r_last <= w_win;
        end
    end

endmodule

// File: rtl/pixel_scheduler.sv
// Walks coord_control through a frame and deals each pixel to one of the
// iteration engines via a round-robin grant.
module pixel_scheduler
    import mandel_pkg::*;
#(
    parameter int unsigned BITS    = 16,
    parameter int unsigned WIDTH   = 320,
    parameter int unsigned HEIGHT  = 240,
    parameter int unsigned ENGINES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           run,
    input  logic [x_bits(BITS)-1:0]        next_x0,
    input  logic [y_bits(BITS)-1:0]        next_y0,
    output logic [x_bits(BITS)-1:0]        x0,
    output logic [y_bits(BITS)-1:0]        y0,
    output logic                           next_frame,
    output logic                           next_row,
    input  logic [ENGINES-1:0]             eng_req,
    output logic [ENGINES-1:0]             eng_grant,
    output logic [idx_bits(WIDTH)-1:0]     job_col,
    output logic [idx_bits(HEIGHT)-1:0]    job_row,
    output logic                           busy,
    output logic                           frame_done
);

    localparam int unsigned CW = idx_bits(WIDTH);
    localparam int unsigned RW = idx_bits(HEIGHT);
    localparam int unsigned XW = x_bits(BITS);
    localparam int unsigned YW = y_bits(BITS);

    sched_state_e r_state, w_state_d;
    logic [XW-1:0] r_x0;
    logic [YW-1:0] r_y0;
    logic [CW-1:0] r_col, w_col_d;
    logic [RW-1:0] r_row, w_row_d;
    logic [1:0]    w_ctrl;
    logic          w_load;
    logic          w_arb_en;
    logic          w_granted;

    // Gate with rst_n so nothing is granted in a reset cycle.
    assign w_arb_en  = (r_state == StIssue) && rst_n;
    assign w_granted = |eng_grant;

    rr_arbiter #(
        .N (ENGINES)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (eng_req),
        .en    (w_arb_en),
        .grant (eng_grant)
    );

    always_comb begin
        w_state_d  = r_state;
        w_col_d    = r_col;
        w_row_d    = r_row;
        w_ctrl     = CTRL_STEP;
        w_load     = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        unique case (r_state)
            StIdle: begin
                busy = 1'b0;
                if (run) begin
                    w_state_d = StFrame;
                end
            end
            StFrame: begin
                w_ctrl    = CTRL_FRAME;
                w_load    = 1'b1;
                w_col_d   = '0;
                w_row_d   = '0;
                w_state_d = StSettle;
            end
            StSettle: begin
                w_state_d = StRow;
            end
            StRow: begin
                w_ctrl    = CTRL_ROW;
                w_load    = 1'b1;
                w_state_d = StIssue;
            end
            StIssue: begin
                if (w_granted) begin
                    w_load = 1'b1;
                    if (r_col == CW'(WIDTH - 1)) begin
                        w_col_d = '0;
                        if (r_row == RW'(HEIGHT - 1)) begin
                            w_state_d = StDone;
                        end else begin
                            w_row_d   = r_row + RW'(1);
                            w_state_d = StRow;
                        end
                    end else begin
                        w_col_d = r_col + CW'(1);
                    end
                end
            end
            StDone: begin
                frame_done = 1'b1;
                w_state_d  = run ? StFrame : StIdle;
            end
            default: begin
                busy      = 1'b0;
                w_state_d = StIdle;
            end
        endcase
    end

    assign next_frame = (w_ctrl == CTRL_FRAME);
    assign next_row   = (w_ctrl == CTRL_ROW);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_x0    <= '0;
            r_y0    <= '0;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_d;
            r_col   <= w_col_d;
            r_row   <= w_row_d;
            if (w_load) begin
                r_x0 <= next_x0;
                r_y0 <= next_y0;
            end
        end
    end

    assign x0      = r_x0;
    assign y0      = r_y0;
    assign job_col = r_col;
    assign job_row = r_row;

endmodule

// File: tb/tb_pixel_scheduler.sv
// Bench for pixel_scheduler on a 4x3 frame with two engines and a simple
// coord_control model (x step 1, row start step 16).
module tb_pixel_scheduler;

    localparam int BITS    = 16;
    localparam int WIDTH   = 4;
    localparam int HEIGHT  = 3;
    localparam int ENGINES = 2;

    logic        clk = 1'b0;
    logic        rst_n, run;
    logic [1:0]  eng_req, eng_grant;
    logic [15:0] next_x0, x0;
    logic [14:0] next_y0, y0;
    logic        next_frame, next_row, busy, frame_done;
    logic [1:0]  job_col, job_row;

    always #5 clk = ~clk;

    pixel_scheduler #(
        .BITS    (BITS),
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .ENGINES (ENGINES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .next_x0    (next_x0),
        .next_y0    (next_y0),
        .x0         (x0),
        .y0         (y0),
        .next_frame (next_frame),
        .next_row   (next_row),
        .eng_req    (eng_req),
        .eng_grant  (eng_grant),
        .job_col    (job_col),
        .job_row    (job_row),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Behavioural coord_control
    logic [15:0] r_row_start;
    always @(posedge clk) begin
        if (!rst_n)          r_row_start <= '0;
        else if (next_frame) r_row_start <= '0;
        else if (next_row)   r_row_start <= r_row_start + 16'd16;
    end
    assign next_x0 = next_frame ? 16'd0 : next_row ? r_row_start : x0 + 16'd1;
    assign next_y0 = next_frame ? 15'd0 : next_row ? r_row_start[14:0] : y0;

    typedef struct {
        int col;
        int row;
        int x0;
        int y0;
    } job_t;

    typedef struct {
        logic [1:0] req;
        logic [1:0] grant;
        logic       nf;
        logic       nr;
        logic       fd;
    } vec_t;

    job_t       sb[$];
    logic [1:0] glog[$];
    vec_t       tbl[23];
    int         n_cmp = 0;
    int         n_err = 0;

    logic        s_nf, s_nr, s_fd, s_busy;
    logic [1:0]  s_grant, s_col, s_row;
    logic [15:0] s_x0;
    logic [14:0] s_y0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_frame();
        for (int r = 0; r < HEIGHT; r++) begin
            for (int c = 0; c < WIDTH; c++) begin
                sb.push_back('{col: c, row: r, x0: 16 * r + c, y0: 16 * r});
            end
        end
    endtask

    // Sample mid-cycle, check any granted job against the scoreboard, advance.
    task automatic cyc();
        job_t j;
        @(negedge clk);
        s_nf    = next_frame;
        s_nr    = next_row;
        s_fd    = frame_done;
        s_busy  = busy;
        s_grant = eng_grant;
        s_col   = job_col;
        s_row   = job_row;
        s_x0    = x0;
        s_y0    = y0;
        chk("strobe_overlap", int'(s_nf & s_nr), 0);
        if (s_grant != 2'b00) begin
            glog.push_back(s_grant);
            chk("grant_onehot", $countones(s_grant), 1);
            chk("grant_in_req", int'((s_grant & ~eng_req) == 2'b00), 1);
            chk("strobe_with_grant", int'(s_nf | s_nr), 0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL job_unexpected: got col %0d row %0d, expected no job",
                         s_col, s_row);
            end else begin
                j = sb.pop_front();
                chk("job_col", int'(s_col), j.col);
                chk("job_row", int'(s_row), j.row);
                chk("job_x0", int'(s_x0), j.x0);
                chk("job_y0", int'(s_y0), j.y0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int t_nf, t_nr, t_fd;
        bit hit;

        tbl[0]  = '{2'b10, 2'b00, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{2'b10, 2'b00, 1'b0, 1'b1, 1'b0};
        for (int k = 3; k <= 6; k++) tbl[k] = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{2'b11, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{2'b11, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{2'b11, 2'b10, 1'b0, 1'b0, 1'b0};
        for (int k = 10; k <= 14; k++) tbl[k] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{2'b11, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{2'b11, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{2'b01, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[18] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[20] = '{2'b11, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[21] = '{2'b11, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[22] = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b1};

        // Reset state
        rst_n = 1'b0; run = 1'b0; eng_req = 2'b11;
        repeat (3) cyc();
        chk("rst_busy", int'(s_busy), 0);
        chk("rst_next_frame", int'(s_nf), 0);
        chk("rst_next_row", int'(s_nr), 0);
        chk("rst_frame_done", int'(s_fd), 0);
        chk("rst_grant", int'(s_grant), 0);
        chk("rst_x0", int'(s_x0), 0);
        chk("rst_y0", int'(s_y0), 0);
        chk("rst_col", int'(s_col), 0);
        chk("rst_row", int'(s_row), 0);

        // Frame 1: full pressure, strobe/done timing and alternating grants
        rst_n = 1'b1; run = 1'b1; eng_req = 2'b11;
        push_frame();
        glog.delete();
        t_nf = -1; t_nr = -1; t_fd = -1;
        for (int c = 0; c < 40 && t_fd < 0; c++) begin
            cyc();
            if (s_nf && t_nf < 0) t_nf = c;
            if (s_nr && t_nr < 0) t_nr = c;
            if (s_fd) t_fd = c;
        end
        chk("f1_next_frame_cycle", t_nf, 1);
        chk("f1_next_row_cycle", t_nr, 3);
        chk("f1_frame_done_cycle", t_fd, 18);
        chk("f1_grant_count", glog.size(), 12);
        for (int i = 0; i < glog.size(); i++) begin
            chk($sformatf("f1_grant%0d", i), int'(glog[i]), (i % 2 == 0) ? 1 : 2);
        end
        chk("f1_jobs_left", sb.size(), 0);

        // Frame 2: per-cycle vector table (engine 1 only, stall, mixed)
        push_frame();
        for (int k = 0; k < 23; k++) begin
            eng_req = tbl[k].req;
            cyc();
            chk($sformatf("vec%0d_grant", k), int'(s_grant), int'(tbl[k].grant));
            chk($sformatf("vec%0d_next_frame", k), int'(s_nf), int'(tbl[k].nf));
            chk($sformatf("vec%0d_next_row", k), int'(s_nr), int'(tbl[k].nr));
            chk($sformatf("vec%0d_frame_done", k), int'(s_fd), int'(tbl[k].fd));
            if (k >= 10 && k <= 14) begin
                chk($sformatf("vec%0d_hold_x0", k), int'(s_x0), 18);
                chk($sformatf("vec%0d_hold_col", k), int'(s_col), 2);
                chk($sformatf("vec%0d_hold_row", k), int'(s_row), 1);
            end
        end
        chk("f2_jobs_left", sb.size(), 0);

        // Frame 3: back-to-back start, then run drops at pixel (1,1)
        push_frame();
        eng_req = 2'b11;
        cyc();
        chk("f3_next_frame", int'(s_nf), 1);
        hit = 1'b0;
        for (int c = 0; c < 30 && !hit; c++) begin
            cyc();
            if (s_grant != 2'b00 && s_col == 2'd1 && s_row == 2'd1) hit = 1'b1;
        end
        chk("f3_reach_1_1", int'(hit), 1);
        run = 1'b0;
        t_fd = -1;
        for (int c = 0; c < 30 && t_fd < 0; c++) begin
            cyc();
            if (s_fd) t_fd = c;
        end
        chk("f3_frame_done_cycle", t_fd, 7);
        chk("f3_jobs_left", sb.size(), 0);
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk($sformatf("f3_idle%0d_busy", c), int'(s_busy), 0);
            chk($sformatf("f3_idle%0d_next_frame", c), int'(s_nf), 0);
        end

        // Frame 4: engine 0 only, reset hits in ISSUE at pixel (2,1)
        run = 1'b1; eng_req = 2'b01;
        push_frame();
        hit = 1'b0;
        for (int c = 0; c < 30 && !hit; c++) begin
            cyc();
            if (s_grant != 2'b00 && s_col == 2'd1 && s_row == 2'd1) hit = 1'b1;
        end
        chk("f4_reach_1_1", int'(hit), 1);
        rst_n = 1'b0;
        cyc();
        chk("rst_cycle_grant", int'(s_grant), 0);
        chk("rst_cycle_col", int'(s_col), 2);
        sb.delete();
        rst_n = 1'b1; run = 1'b0; eng_req = 2'b11;
        cyc();
        chk("post_rst_x0", int'(s_x0), 0);
        chk("post_rst_y0", int'(s_y0), 0);
        chk("post_rst_col", int'(s_col), 0);
        chk("post_rst_row", int'(s_row), 0);
        chk("post_rst_busy", int'(s_busy), 0);
        chk("post_rst_strobes", int'({s_nf, s_nr, s_fd}), 0);
        chk("post_rst_grant", int'(s_grant), 0);

        // Restart: engine 0 must win first again
        run = 1'b1;
        push_frame();
        glog.delete();
        t_fd = -1;
        for (int c = 0; c < 40 && t_fd < 0; c++) begin
            cyc();
            if (s_fd) t_fd = c;
        end
        chk("f5_frame_done_cycle", t_fd, 18);
        chk("f5_grant_count", glog.size(), 12);
        if (glog.size() > 0) begin
            chk("f5_first_grant", int'(glog[0]), 1);
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL f5_first_grant: got no grant, expected 1");
        end
        chk("f5_jobs_left", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
